sha_sched_ctrl: RTL and testbench

SHA_SCHED_CTRL -- requirements
Module: sha_sched_ctrl

---
 rtl/sha_sched_if.sv | 26 ++
 rtl/sha_sched_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sha_sched_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_sched_if.sv
// Handshake and data bundle between the SHA-256 schedule controller, its
// message-word source, the schedule unit and the expanded-word consumer.
`timescale 1ns/1ps
interface sha_sched_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_run;
    logic [7:0]  m_delay0;
    logic [31:0] m_in0;
    logic [31:0] m_out0;
    logic        w_valid;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        w_last;

    modport master (
        output s_valid, s_data, m_out0,
        input  s_ready, m_run, m_delay0, m_in0, w_valid, w_data, w_idx, w_last
    );

    modport slave (
        input  s_valid, s_data, m_out0,
        output s_ready, m_run, m_delay0, m_in0, w_valid, w_data, w_idx, w_last
    );
endinterface

// File: rtl/sha_sched_ctrl.sv
// SHA-256 message-schedule controller: double-buffers 16-word blocks and
// sequences an external schedule unit, streaming W0..W63 for each block.
`timescale 1ns/1ps
module sha_sched_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [7:0]       cfg_delay,
    sha_sched_if.slave       bus,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_done
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_FEED   = 3'd3,
        S_GAP    = 3'd4,
        S_EXPAND = 3'd5
    } state_t;

    state_t           r_state;
    logic [31:0]      r_mem [2][16];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [3:0]       r_wr_ptr;
    logic [7:0]       r_delay;
    logic [7:0]       r_wait;
    logic [5:0]       r_idx;
    logic             r_run;
    logic             r_wv;
    logic             r_exp;
    logic             r_last;
    logic [31:0]      r_in0;
    logic [31:0]      r_fdata;
    logic [CNT_W-1:0] r_done;

    logic             w_accept;
    logic             w_fill_done;
    logic             w_release;
    logic [1:0]       w_full_nxt;
    logic [31:0]      w_word_first;
    logic [31:0]      w_word_next;

    assign w_accept     = bus.s_valid & ~r_full[r_wr_bank] & ~clr;
    assign w_fill_done  = w_accept & (r_wr_ptr == 4'd15);
    assign w_release    = (r_state == S_FEED) & (r_idx == 6'd15);
    assign w_word_first = r_mem[r_rd_bank][4'd0];
    assign w_word_next  = r_mem[r_rd_bank][r_idx[3:0] + 4'd1];

    // Next full flags: the read bank empties on its last feed cycle while the
    // write bank (always the other one then) may complete in the same cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end else begin
            w_full_nxt[r_rd_bank] = r_full[r_rd_bank];
        end
        if (w_fill_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end else begin
            w_full_nxt[r_wr_bank] = w_full_nxt[r_wr_bank];
        end
    end

    // Message word storage for both banks.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][r_wr_ptr] <= bus.s_data;
        end
    end

    // Bank occupancy and write/read bank pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_ptr  <= 4'd0;
        end else if (clr) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_ptr  <= 4'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 4'd1;
                if (r_wr_ptr == 4'd15) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Block sequencer: run pulse, optional delay, feed W0..W15, gap, stream W16..W63.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
            r_delay <= 8'd0;
            r_wait  <= 8'd0;
            r_idx   <= 6'd0;
            r_wv    <= 1'b0;
            r_exp   <= 1'b0;
            r_last  <= 1'b0;
            r_in0   <= 32'd0;
            r_fdata <= 32'd0;
            r_done  <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
            r_wait  <= 8'd0;
            r_idx   <= 6'd0;
            r_wv    <= 1'b0;
            r_exp   <= 1'b0;
            r_last  <= 1'b0;
            r_in0   <= 32'd0;
            r_fdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state <= S_START;
                        r_run   <= 1'b1;
                        r_delay <= cfg_delay;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_run <= 1'b0;
                    if (r_delay == 8'd0) begin
                        r_state <= S_FEED;
                        r_wv    <= 1'b1;
                        r_idx   <= 6'd0;
                        r_in0   <= w_word_first;
                        r_fdata <= w_word_first;
                    end else begin
                        r_state <= S_WAIT;
                        r_wait  <= r_delay;
                    end
                end
                S_WAIT: begin
                    if (r_wait == 8'd1) begin
                        r_state <= S_FEED;
                        r_wv    <= 1'b1;
                        r_idx   <= 6'd0;
                        r_in0   <= w_word_first;
                        r_fdata <= w_word_first;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                S_FEED: begin
                    if (r_idx == 6'd15) begin
                        r_state <= S_GAP;
                        r_wv    <= 1'b0;
                        r_idx   <= 6'd0;
                        r_in0   <= 32'd0;
                        r_fdata <= 32'd0;
                    end else begin
                        r_idx   <= r_idx + 6'd1;
                        r_in0   <= w_word_next;
                        r_fdata <= w_word_next;
                    end
                end
                S_GAP: begin
                    r_state <= S_EXPAND;
                    r_wv    <= 1'b1;
                    r_exp   <= 1'b1;
                    r_idx   <= 6'd16;
                end
                S_EXPAND: begin
                    if (r_idx == 6'd63) begin
                        r_wv   <= 1'b0;
                        r_exp  <= 1'b0;
                        r_last <= 1'b0;
                        r_idx  <= 6'd0;
                        r_done <= r_done + CNT_W'(1);
                        // The read pointer already moved to the other bank at the end of feed.
                        if (r_full[r_rd_bank]) begin
                            r_state <= S_START;
                            r_run   <= 1'b1;
                            r_delay <= cfg_delay;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_idx  <= r_idx + 6'd1;
                        r_last <= (r_idx == 6'd62);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Expanded words come straight from the unit's registered output.
    assign bus.s_ready  = ~r_full[r_wr_bank];
    assign bus.m_run    = r_run;
    assign bus.m_delay0 = r_delay;
    assign bus.m_in0    = r_in0;
    assign bus.w_valid  = r_wv;
    assign bus.w_data   = r_exp ? bus.m_out0 : r_fdata;
    assign bus.w_idx    = r_idx;
    assign bus.w_last   = r_last;
    assign busy         = (r_state != S_IDLE);
    assign blocks_done  = r_done;
endmodule

// File: tb/tb_sha_sched_ctrl.sv
// Randomized scoreboard bench for sha_sched_ctrl with a behavioural SHA-256
// schedule unit and a reference schedule computed per block.
`timescale 1ns/1ps
module tb_sha_sched_ctrl;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [7:0]    cfg_delay;
    logic          busy;
    logic [CW-1:0] blocks_done;

    sha_sched_if bus();

    sha_sched_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cfg_delay(cfg_delay),
        .bus(bus), .busy(busy), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          runs_q[$];
    int          tests = 0, fails = 0;
    int          cyc = 0, run_cyc = 0, last_lat = 0;
    int          n_words = 0, n_last = 0, n_runs = 0;
    bit          prev_run = 1'b0, stall_seen = 1'b0;
    logic [31:0] seen [64];
    int          exp_done = 0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: full 64-word schedule of a block, queued as expected stream.
    task automatic push_block(input logic [31:0] blk [16]);
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) begin
            e.idx = 6'(i); e.data = w[i]; e.last = (i == 63);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_block(input logic [31:0] blk [16]);
        bit rdy;
        int n;
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = blk[i];
            n = 0;
            do begin
                @(negedge clk); rdy = bus.s_ready;
                @(posedge clk); n++;
            end while (!rdy && n < 1000);
            if (!rdy) begin
                fails++; tests++;
                $display("FAIL send_timeout: word %0d never accepted", i);
            end
            #1;
        end
        bus.s_valid = 1'b0;
        push_block(blk);
    endtask

    task automatic rand_block(output logic [31:0] blk [16]);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (3) @(posedge clk);
        do begin @(negedge clk); n++; end while ((busy || exp_q.size() != 0) && n < 3000);
        if (busy || exp_q.size() != 0) begin
            fails++; tests++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d", busy, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
        chk({tag, "_m_run"}, 32'(bus.m_run), 32'd0);
        chk({tag, "_m_delay0"}, 32'(bus.m_delay0), 32'd0);
        chk({tag, "_m_in0"}, bus.m_in0, 32'd0);
        chk({tag, "_w_valid"}, 32'(bus.w_valid), 32'd0);
        chk({tag, "_w_data"}, bus.w_data, 32'd0);
        chk({tag, "_w_idx"}, 32'(bus.w_idx), 32'd0);
        chk({tag, "_w_last"}, 32'(bus.w_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_blocks_done"}, 32'(blocks_done), 32'd0);
    endtask

    always @(posedge clk) cyc++;

    // Behavioural schedule unit: captures W0..W15 from m_in0, registers W16.. after.
    int          u_t = 0, u_d = 0, u_k = 0;
    bit          u_act = 1'b0;
    logic [31:0] u_w [64];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_act = 1'b0; u_t = 0; u_d = 0;
            bus.m_out0 <= 32'd0;
        end else begin
            if (bus.m_run) begin
                u_act = 1'b1; u_t = 0; u_d = int'(bus.m_delay0);
            end else if (u_act) begin
                u_t = u_t + 1;
            end
            if (u_act && u_t >= u_d + 1 && u_t <= u_d + 16) u_w[u_t-u_d-1] = bus.m_in0;
            if (u_act && u_t >= u_d + 17 && u_t <= u_d + 64) begin
                u_k = u_t - u_d - 1;
                u_w[u_k] = sig1(u_w[u_k-2]) + u_w[u_k-7] + sig0(u_w[u_k-15]) + u_w[u_k-16];
                bus.m_out0 <= u_w[u_k];
            end
        end
    end

    // Monitor: pops the scoreboard on every valid expanded word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.m_run) begin
                n_runs++; run_cyc = cyc; runs_q.push_back(cyc);
                tests++;
                if (prev_run) begin
                    fails++; $display("FAIL run_pulse: m_run high two cycles at cycle %0d", cyc);
                end
            end
            prev_run = bus.m_run;
            if (bus.s_valid && !bus.s_ready) stall_seen = 1'b1;
            if (bus.w_valid) begin
                n_words++;
                if (bus.w_last) n_last++;
                seen[bus.w_idx] = bus.w_data;
                if (bus.w_idx == 6'd16) last_lat = cyc - run_cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: idx=%0d data=%h, none expected", bus.w_idx, bus.w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.w_idx !== e.idx || bus.w_data !== e.data || bus.w_last !== e.last) begin
                        fails++;
                        $display("FAIL word: got idx=%0d data=%h last=%0d, expected idx=%0d data=%h last=%0d",
                                 bus.w_idx, bus.w_data, bus.w_last, e.idx, e.data, e.last);
                    end
                    tests++;
                    if (bus.m_in0 !== ((e.idx < 6'd16) ? e.data : 32'd0)) begin
                        fails++;
                        $display("FAIL m_in0: got %h at idx %0d, expected %h", bus.m_in0, e.idx,
                                 (e.idx < 6'd16) ? e.data : 32'd0);
                    end
                end
            end
        end else begin
            prev_run = 1'b0;
        end
    end

    initial begin
        logic [31:0] abc [16];
        logic [31:0] blk [16];
        int d, n, nw0, nl0, nr0;

        rst = 1'b1; clr = 1'b0; cfg_delay = 8'd0;
        bus.s_valid = 1'b0; bus.s_data = 32'd0;
        for (int i = 0; i < 16; i++) abc[i] = 32'd0;
        abc[0] = 32'h61626380; abc[15] = 32'h00000018;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // "abc" block, no delay
        runs_q.delete();
        send_block(abc); exp_done++;
        wait_idle();
        chk("abc_w16", seen[16], 32'h61626380);
        chk("abc_w17", seen[17], 32'h000F0000);
        chk("abc_lat_d0", 32'(last_lat), 32'd18);
        chk("abc_runs", 32'(runs_q.size()), 32'd1);
        chk("abc_done", 32'(blocks_done), 32'(exp_done % 8));

        // Same block with delay 5
        cfg_delay = 8'd5;
        send_block(abc); exp_done++;
        wait_idle();
        chk("abc_d5_lat", 32'(last_lat), 32'd23);
        chk("abc_d5_w17", seen[17], 32'h000F0000);

        // Three blocks streamed back-to-back
        d = $urandom_range(0, 3);
        cfg_delay = 8'(d);
        stall_seen = 1'b0; nw0 = n_words; nl0 = n_last;
        runs_q.delete();
        for (int b = 0; b < 3; b++) begin
            rand_block(blk); send_block(blk); exp_done++;
        end
        wait_idle();
        chk("stream_stall", 32'(stall_seen), 32'd1);
        chk("stream_words", 32'(n_words - nw0), 32'd192);
        chk("stream_last", 32'(n_last - nl0), 32'd3);
        chk("stream_runs", 32'(runs_q.size()), 32'd3);
        if (runs_q.size() == 3) begin
            chk("stream_b2b_1", 32'(runs_q[1] - runs_q[0]), 32'(66 + d));
            chk("stream_b2b_2", 32'(runs_q[2] - runs_q[1]), 32'(66 + d));
        end
        chk("stream_done", 32'(blocks_done), 32'(exp_done % 8));

        // Delay change while a block is in flight
        cfg_delay = 8'd2;
        rand_block(blk); send_block(blk); exp_done++;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.w_valid && bus.w_idx == 6'd3) && n < 200);
        #1 cfg_delay = 8'd7;
        wait_idle();
        chk("cfgchg_lat", 32'(last_lat), 32'd20);
        chk("cfgchg_done", 32'(blocks_done), 32'(exp_done % 8));

        // Soft abort during expansion with a second block buffered
        cfg_delay = 8'd1;
        rand_block(blk); send_block(blk);
        rand_block(blk); send_block(blk);
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.w_valid && bus.w_idx == 6'd30) && n < 300);
        chk("clr_reached_expand", 32'(bus.w_idx), 32'd30);
        #1 clr = 1'b1;
        bus.s_valid = 1'b1; bus.s_data = 32'hDEADBEEF;
        @(posedge clk); #1 clr = 1'b0; bus.s_valid = 1'b0;
        exp_q.delete();
        nr0 = n_runs;
        @(negedge clk);
        chk("clr_w_valid", 32'(bus.w_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_s_ready", 32'(bus.s_ready), 32'd1);
        chk("clr_done", 32'(blocks_done), 32'(exp_done % 8));
        repeat (80) @(negedge clk);
        chk("clr_stays_idle", 32'(busy), 32'd0);
        chk("clr_no_run", 32'(n_runs - nr0), 32'd0);
        @(posedge clk); #1;

        // Hard reset in the middle of feed
        cfg_delay = 8'd0;
        rand_block(blk); send_block(blk);
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.w_valid && bus.w_idx == 6'd7) && n < 200);
        #1 rst = 1'b1;
        #1 chk_reset("midrst");
        exp_q.delete(); exp_done = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        d = $urandom_range(0, 4);
        cfg_delay = 8'(d);
        rand_block(blk); send_block(blk); exp_done++;
        wait_idle();
        chk("postrst_lat", 32'(last_lat), 32'(18 + d));
        chk("postrst_done", 32'(blocks_done), 32'd1);

        // Counter wrap at 2^CW
        for (int b = 0; b < 6; b++) begin
            cfg_delay = 8'($urandom_range(0, 2));
            rand_block(blk); send_block(blk); exp_done++;
        end
        wait_idle();
        chk("wrap_at_max", 32'(blocks_done), 32'd7);
        rand_block(blk); send_block(blk); exp_done++;
        wait_idle();
        chk("wrap_to_zero", 32'(blocks_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
